// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to its consumers.
// The generator drives the master side; readers take the slave side.
interface vga_timing_gen_if #(
    parameter int CW = 10
);
    logic          pix_tick;
    logic          hsync;
    logic          vsync;
    logic          video_active;
    logic [CW-1:0] pixel_x;
    logic [CW-1:0] pixel_y;
    logic          line_start;
    logic          frame_start;
    logic          vblank_start;
    logic [7:0]    frame_cnt;
    logic          win_active;
    logic [CW-1:0] win_x;
    logic [CW-1:0] win_y;

    modport master (
        output pix_tick, hsync, vsync, video_active,
        output pixel_x, pixel_y,
        output line_start, frame_start, vblank_start,
        output frame_cnt, win_active, win_x, win_y
    );

    modport slave (
        input pix_tick, hsync, vsync, video_active,
        input pixel_x, pixel_y,
        input line_start, frame_start, vblank_start,
        input frame_cnt, win_active, win_x, win_y
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Registered raster timing generator with strobes and frame counter.
// Define VGA_WINDOW_EN to build the window-relative coordinate logic.
module vga_timing_gen #(
    parameter int H_D     = 640,
    parameter int H_FP    = 16,
    parameter int H_SP    = 96,
    parameter int H_BP    = 48,
    parameter int V_D     = 480,
    parameter int V_FP    = 10,
    parameter int V_SP    = 2,
    parameter int V_BP    = 33,
    parameter bit H_POL   = 1'b0,
    parameter bit V_POL   = 1'b0,
    parameter int CLK_DIV = 1,
    parameter int CW      = 10,
    parameter int WIN_X0  = 80,
    parameter int WIN_W   = 480,
    parameter int WIN_Y0  = 0,
    parameter int WIN_H   = 480
) (
    input  logic             clk,
    input  logic             reset,
    vga_timing_gen_if.master vga
);
    localparam int H_T = H_D + H_FP + H_SP + H_BP;
    localparam int V_T = V_D + V_FP + V_SP + V_BP;
    localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    // One extra bit so bounds equal to 2^CW stay representable.
    localparam logic [CW:0] H_LAST = (CW+1)'(H_T - 1);
    localparam logic [CW:0] V_LAST = (CW+1)'(V_T - 1);
    localparam logic [CW:0] HD_E   = (CW+1)'(H_D);
    localparam logic [CW:0] VD_E   = (CW+1)'(V_D);
    localparam logic [CW:0] HS_B   = (CW+1)'(H_D + H_FP);
    localparam logic [CW:0] HS_E   = (CW+1)'(H_D + H_FP + H_SP);
    localparam logic [CW:0] VS_B   = (CW+1)'(V_D + V_FP);
    localparam logic [CW:0] VS_E   = (CW+1)'(V_D + V_FP + V_SP);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end

    if ((longint'(H_T) > (longint'(1) << CW)) ||
        (longint'(V_T) > (longint'(1) << CW))) begin : g_bad_cw
        $error("vga_timing_gen: CW too small for H_T/V_T");
    end

    if (WIN_X0 < 0 || WIN_W < 0 ||
        WIN_Y0 < 0 || WIN_H < 0) begin : g_bad_win_sign
        $error("vga_timing_gen: window parameters must be >= 0");
    end

    logic [DW-1:0] div;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [7:0]    fcnt;
    logic [CW:0]   xe;
    logic [CW:0]   ye;
    logic          tick;
    logic          x_end;
    logic          y_end;
    logic          hs_n;
    logic          vs_n;
    logic          act_n;

    assign xe    = {1'b0, x};
    assign ye    = {1'b0, y};
    assign tick  = (div == DIV_LAST);
    assign x_end = (xe == H_LAST);
    assign y_end = (ye == V_LAST);

    assign hs_n  = (xe >= HS_B && xe < HS_E) ? H_POL : ~H_POL;
    assign vs_n  = (ye >= VS_B && ye < VS_E) ? V_POL : ~V_POL;
    assign act_n = (xe < HD_E) && (ye < VD_E);

    always_ff @(posedge clk) begin
        if (reset) begin
            div                <= '0;
            x                  <= '0;
            y                  <= '0;
            fcnt               <= '0;
            vga.pix_tick       <= 1'b0;
            vga.line_start     <= 1'b0;
            vga.frame_start    <= 1'b0;
            vga.vblank_start   <= 1'b0;
            vga.hsync          <= ~H_POL;
            vga.vsync          <= ~V_POL;
            vga.video_active   <= 1'b0;
            vga.pixel_x        <= '0;
            vga.pixel_y        <= '0;
            vga.frame_cnt      <= '0;
        end else begin
            div                <= tick ? '0 : div + DW'(1);
            vga.pix_tick       <= tick;
            vga.line_start     <= tick && (x == '0);
            vga.frame_start    <= tick && (x == '0) && (y == '0);
            vga.vblank_start   <= tick && (x == '0) && (ye == VD_E);
            if (tick) begin
                x <= x_end ? '0 : x + CW'(1);
                if (x_end) begin
                    y <= y_end ? '0 : y + CW'(1);
                    if (y_end) begin
                        fcnt <= fcnt + 8'd1;
                    end
                end
                vga.hsync        <= hs_n;
                vga.vsync        <= vs_n;
                vga.video_active <= act_n;
                vga.pixel_x      <= x;
                vga.pixel_y      <= y;
                vga.frame_cnt    <= fcnt;
            end
        end
    end

`ifdef VGA_WINDOW_EN
    localparam logic [CW:0]   WX_B   = (CW+1)'(WIN_X0);
    localparam logic [CW:0]   WX_E   = (CW+1)'(WIN_X0 + WIN_W);
    localparam logic [CW:0]   WY_B   = (CW+1)'(WIN_Y0);
    localparam logic [CW:0]   WY_E   = (CW+1)'(WIN_Y0 + WIN_H);
    localparam logic [CW-1:0] WX_OFF = CW'(WIN_X0);
    localparam logic [CW-1:0] WY_OFF = CW'(WIN_Y0);

    if (WIN_X0 + WIN_W > H_D ||
        WIN_Y0 + WIN_H > V_D) begin : g_bad_win
        $error("vga_timing_gen: window exceeds visible area");
    end

    logic          win_n;
    logic [CW-1:0] wx_n;
    logic [CW-1:0] wy_n;

    assign win_n = act_n &&
                   (xe >= WX_B) && (xe < WX_E) &&
                   (ye >= WY_B) && (ye < WY_E);
    assign wx_n  = win_n ? x - WX_OFF : '0;
    assign wy_n  = win_n ? y - WY_OFF : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            vga.win_active <= 1'b0;
            vga.win_x      <= '0;
            vga.win_y      <= '0;
        end else if (tick) begin
            vga.win_active <= win_n;
            vga.win_x      <= wx_n;
            vga.win_y      <= wy_n;
        end
    end
`else
    // Without the window the whole visible area is the window.
    assign vga.win_active = vga.video_active;
    assign vga.win_x      = vga.pixel_x;
    assign vga.win_y      = vga.pixel_y;
`endif
endmodule
